// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of the shared 8-digit seven-segment display, with a minimum hold time per grant.
// Optional leading-zero blanking of digit_en is enabled by defining SEG_LZB_EN.
module seg_disp_arbiter #(
  parameter int NREQ    = 4,
  parameter int CLK_KHZ = 5000,
  parameter int HOLD_MS = 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   data,
  input  logic [31:0]          idle_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [31:0]          q_a,
  output logic [7:0]           digit_en
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(CLK_KHZ + 1);
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_KHZ - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_MS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
  localparam logic [NREQ-1:0] ONE     = NREQ'(1);

  typedef enum logic [1:0] {IDLE, OWN, LINGER} state_t;

  state_t          state;
  logic [RW-1:0]   owner;
  logic [RW-1:0]   rr;
  logic [PW-1:0]   pre_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [31:0]     words [NREQ];

  logic            tick;
  logic            hold_sat;
  logic            hold_done;
  logic            owner_req;
  logic [NREQ-1:0] cand;
  logic            found;
  logic [RW-1:0]   winner;
  logic [RW-1:0]   idx;
  logic            grant_now;
  logic            idle_now;
  logic            linger_now;
  logic [31:0]     q_nxt;

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = data[32*i +: 32];
  end

  // hold_done is high on the edge where the hold counter reaches HOLD_MS, then stays high
  assign tick      = (pre_cnt == PRE_MAX);
  assign hold_sat  = (hold_cnt == HOLD_MAX);
  assign hold_done = hold_sat || (tick && (hold_cnt == HOLD_LAST));
  assign owner_req = req[owner];
  assign busy      = (state != IDLE);
  assign cand      = (state == OWN) ? (req & ~gnt) : req;

  always_comb begin
    found  = 1'b0;
    winner = rr;
    idx    = rr;
    for (int i = 1; i <= NREQ; i++) begin
      idx = RW'((int'(rr) + i) % NREQ);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // A release on the same edge as a preemption resolves as a release
  always_comb begin
    grant_now  = 1'b0;
    idle_now   = 1'b0;
    linger_now = 1'b0;
    case (state)
      IDLE: grant_now = found;
      OWN: begin
        if (!owner_req) begin
          if (!hold_done)  linger_now = 1'b1;
          else if (found)  grant_now  = 1'b1;
          else             idle_now   = 1'b1;
        end else if (hold_done && found) begin
          grant_now = 1'b1;
        end
      end
      LINGER: begin
        if (hold_done) begin
          grant_now = found;
          idle_now  = !found;
        end
      end
      default: idle_now = 1'b1;
    endcase
  end

  always_comb begin
    q_nxt = q_a;
    if (grant_now)
      q_nxt = words[winner];
    else if (state == IDLE || idle_now)
      q_nxt = idle_data;
    else if (state == OWN && !linger_now)
      q_nxt = words[owner];
  end

`ifdef SEG_LZB_EN
  function automatic logic [7:0] lzb_mask(input logic [31:0] w);
    lzb_mask = {|w[31:28], |w[31:24], |w[31:20], |w[31:16],
                |w[31:12], |w[31:8],  |w[31:4],  1'b1};
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr       <= RW'(NREQ - 1);
      pre_cnt  <= '0;
      hold_cnt <= '0;
      q_a      <= '0;
      digit_en <= 8'hFF;
    end else begin
      q_a <= q_nxt;
`ifdef SEG_LZB_EN
      digit_en <= lzb_mask(q_nxt);
`endif
      if (grant_now) begin
        state    <= OWN;
        owner    <= winner;
        rr       <= winner;
        gnt      <= ONE << winner;
        pre_cnt  <= '0;
        hold_cnt <= '0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (tick && !hold_sat)
          hold_cnt <= hold_cnt + 1'b1;
        if (idle_now) begin
          state <= IDLE;
          gnt   <= '0;
        end else if (linger_now) begin
          state <= LINGER;
          gnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with CLK_KHZ=4, HOLD_MS=2 (8-cycle hold).
// Define SEG_LZB_EN for both files to check the blanking build.
module tb_seg_disp_arbiter;

  localparam int NREQ = 4;

`ifdef SEG_LZB_EN
  localparam logic [7:0] DE_EE   = 8'h03;
  localparam logic [7:0] DE_42   = 8'h03;
  localparam logic [7:0] DE_1A00 = 8'h0F;
  localparam logic [7:0] DE_ZERO = 8'h01;
`else
  localparam logic [7:0] DE_EE   = 8'hFF;
  localparam logic [7:0] DE_42   = 8'hFF;
  localparam logic [7:0] DE_1A00 = 8'hFF;
  localparam logic [7:0] DE_ZERO = 8'hFF;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  data;
  logic [31:0]         idle_data;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic [31:0]         q_a;
  logic [7:0]          digit_en;

  int checks = 0;
  int fails  = 0;

  seg_disp_arbiter #(.NREQ(NREQ), .CLK_KHZ(4), .HOLD_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .idle_data(idle_data),
    .gnt(gnt), .busy(busy), .q_a(q_a), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_data = 32'h0000_00EE;
    do_reset();
    rst_n = 1'b0;
    step(1);
    checks++; if (gnt !== 4'b0000) begin fails++; $display("[TB] FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (q_a !== 32'h0) begin fails++; $display("[TB] FAIL reset_q: got %h want 00000000", q_a); end
    checks++; if (digit_en !== 8'hFF) begin fails++; $display("[TB] FAIL reset_den: got %h want ff", digit_en); end
    rst_n = 1'b1;
    step(1);
    checks++; if (q_a !== 32'h0000_00EE) begin fails++; $display("[TB] FAIL idle_q: got %h want 000000ee", q_a); end
    checks++; if (digit_en !== DE_EE) begin fails++; $display("[TB] FAIL idle_den: got %h want %h", digit_en, DE_EE); end
    checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin fails++; $display("[TB] FAIL idle_state: got busy=%b gnt=%b want 0/0000", busy, gnt); end
    idle_data = 32'h0000_0077;
    step(1);
    checks++; if (q_a !== 32'h0000_0077) begin fails++; $display("[TB] FAIL idle_track: got %h want 00000077", q_a); end
    idle_data = 32'h0000_00EE;
    step(1);
  endtask

  task automatic test_single_grant();
    data[64 +: 32] = 32'h1234_5678;
    req = 4'b0100;
    step(1);
    checks++; if (gnt !== 4'b0100) begin fails++; $display("[TB] FAIL single_gnt: got %b want 0100", gnt); end
    checks++; if (q_a !== 32'h1234_5678) begin fails++; $display("[TB] FAIL single_q: got %h want 12345678", q_a); end
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    data[64 +: 32] = 32'h0000_0042;
    step(1);
    checks++; if (q_a !== 32'h0000_0042) begin fails++; $display("[TB] FAIL live_q: got %h want 00000042", q_a); end
    checks++; if (digit_en !== DE_42) begin fails++; $display("[TB] FAIL live_den: got %h want %h", digit_en, DE_42); end
    req = '0;
    step(7);
    checks++; if (busy !== 1'b0 || q_a !== 32'h0000_00EE) begin fails++; $display("[TB] FAIL single_end: got busy=%b q=%h want 0/000000ee", busy, q_a); end
  endtask

  task automatic test_linger();
    data[32 +: 32] = 32'h0000_00A5;
    req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step(1);
      checks++; if (gnt !== 4'b0010 || q_a !== 32'h0000_00A5) begin fails++; $display("[TB] FAIL linger_own%0d: got gnt=%b q=%h want 0010/000000a5", c, gnt, q_a); end
    end
    req = '0;
    step(1);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin fails++; $display("[TB] FAIL linger_enter: got gnt=%b busy=%b want 0000/1", gnt, busy); end
    data[32 +: 32] = 32'h0000_00FF;
    req = 4'b0010;
    step(4);
    checks++; if (busy !== 1'b1 || gnt !== 4'b0000 || q_a !== 32'h0000_00A5) begin fails++; $display("[TB] FAIL linger_hold: got busy=%b gnt=%b q=%h want 1/0000/000000a5", busy, gnt, q_a); end
    req = '0;
    step(1);
    checks++; if (busy !== 1'b0 || q_a !== 32'h0000_00EE) begin fails++; $display("[TB] FAIL linger_exit: got busy=%b q=%h want 0/000000ee", busy, q_a); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_gnt [4];
    logic [31:0] exp_q   [4];
    exp_gnt = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_q   = '{32'hD000_0000, 32'hD111_1111, 32'hD333_3333, 32'hD000_0000};
    data = {32'hD333_3333, 32'hD222_2222, 32'hD111_1111, 32'hD000_0000};
    do_reset();
    req = 4'b1011;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        step(1);
        checks++;
        if (gnt !== exp_gnt[s] || q_a !== exp_q[s]) begin
          fails++;
          $display("[TB] FAIL rr_seg%0d_cyc%0d: got gnt=%b q=%h want %b/%h", s, c, gnt, q_a, exp_gnt[s], exp_q[s]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_mid_reset();
    data[64 +: 32] = 32'hBEEF_0002;
    data[96 +: 32] = 32'hBEEF_0003;
    do_reset();
    req = 4'b0100;
    step(3);
    checks++; if (gnt !== 4'b0100) begin fails++; $display("[TB] FAIL midrst_pre: got %b want 0100", gnt); end
    rst_n = 1'b0;
    req = 4'b1100;
    step(1);
    checks++; if (gnt !== 4'b0000 || q_a !== 32'h0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_drop: got gnt=%b q=%h busy=%b want 0000/0/0", gnt, q_a, busy); end
    rst_n = 1'b1;
    step(1);
    checks++; if (gnt !== 4'b0100 || q_a !== 32'hBEEF_0002) begin fails++; $display("[TB] FAIL midrst_rr: got gnt=%b q=%h want 0100/beef0002", gnt, q_a); end
    req = '0;
  endtask

  task automatic test_blanking();
    data[0 +: 32] = 32'h0000_1A00;
    do_reset();
    req = 4'b0001;
    step(1);
    checks++; if (q_a !== 32'h0000_1A00 || digit_en !== DE_1A00) begin fails++; $display("[TB] FAIL lzb_1a00: got q=%h den=%h want 00001a00/%h", q_a, digit_en, DE_1A00); end
    data[0 +: 32] = 32'h0;
    step(1);
    checks++; if (q_a !== 32'h0 || digit_en !== DE_ZERO) begin fails++; $display("[TB] FAIL lzb_zero: got q=%h den=%h want 00000000/%h", q_a, digit_en, DE_ZERO); end
    data[0 +: 32] = 32'h8000_0000;
    step(1);
    checks++; if (digit_en !== 8'hFF) begin fails++; $display("[TB] FAIL lzb_full: got %h want ff", digit_en); end
    req = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    data      = '0;
    idle_data = '0;
    test_reset();
    test_single_grant();
    test_linger();
    test_round_robin();
    test_mid_reset();
    test_blanking();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
Arbitrates the shared 8-digit seven-segment display between several requesters, e.g. song index, note/pitch readout and playback timer. Produces the 32-bit packed hex word and a per-digit enable mask consumed by the display multiplexer.
Enforces a minimum on-screen time per owner so readouts stay legible. Rotates ownership round-robin when requesters contend. Shows a default word when nobody requests.

Parameters:
NREQ, 4, number of requesters (2..8)
CLK_KHZ, 5000, clk cycles per millisecond tick
HOLD_MS, 500, minimum display time per grant, in ms (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req  in  NREQ  per-requester display request, level
data  in  32*NREQ  requester i word at [32i+31:32i], 8 hex nibbles, nibble 0 = rightmost digit
idle_data  in  32  word shown when no owner
gnt  out  NREQ  one-hot grant, at most one bit set
busy  out  1  high in OWN or LINGER
q_a  out  32  registered display word to digit multiplexer
digit_en  out  8  registered per-digit enable, bit k = nibble k

Behaviour:
- Reset, sampled on clk edge with rst_n=0. State=IDLE, gnt=0, busy=0, q_a=0, digit_en=8'hFF, rr pointer=NREQ-1 (req[0] wins first), ms prescaler=0, hold counter=0. Reset mid-grant drops gnt on that same edge.
- Timing. Prescaler counts 0..CLK_KHZ-1; ms tick on wrap. Prescaler and hold counter clear on every new grant. hold_done asserts once hold counter reaches HOLD_MS (exactly HOLD_MS*CLK_KHZ cycles after grant edge) and saturates.
- Arbitration. Winner = first set req bit searching from (rr+1) mod NREQ upward with wrap. On grant, rr <= winner.
- IDLE: q_a <= idle_data each cycle. Any req set -> OWN with gnt=onehot(winner) on the next edge. q_a <= data[winner] on that same edge (1-cycle latency req->gnt/q_a).
- OWN: q_a <= data[owner] every cycle (live tracking, 1-cycle latency).
  - Owner req=0 and !hold_done -> LINGER; gnt<=0, q_a frozen at last value.
  - Owner req=0 and hold_done -> arbitrate among remaining reqs: winner -> OWN(new); none -> IDLE.
  - Owner req=1, hold_done, another req pending -> preempt: grant next round-robin requester on the same edge.
  - Owner req=1, no other pending -> stay. Hold counter saturated; no re-grant.
- LINGER: gnt=0, q_a held. hold_done -> arbitrate (winner -> OWN, none -> IDLE). Requests arriving in LINGER wait, including the previous owner's.
- busy = (state != IDLE).
- Simultaneous events. Preemption and owner release on the same edge resolve as release. A newly set req is seen only at the next arbitration point.
- gnt never has more than one bit set. Between owners, gnt goes directly old->new with no idle cycle when handoff is from OWN.
- data[] not owned is ignored. q_a/digit_en change only on clk edges.

Optional Feature:
SEG_LZB_EN
- Defined: digit_en is registered with q_a from the value loaded into q_a. Leading zero nibbles from digit 7 downward are disabled, stopping at the first nonzero nibble. Digit 0 is always enabled. Examples: q_a=32'h0000_0000 -> digit_en=8'h01; 32'h0000_1A00 -> 8'h0F.
- Undefined: digit_en is constant 8'hFF after reset. No blanking logic is synthesised.

Test Plan:
All scenarios use CLK_KHZ=4, HOLD_MS=2, so hold = 8 cycles.
- Reset/idle: rst_n=0 two cycles, then idle_data=32'h0000_00EE, req=0 -> gnt=0, busy=0, q_a=32'h0000_00EE one cycle after reset release.
- Single grant/live track: req=4'b0100, data[2]=32'h1234_5678 -> next edge gnt=4'b0100, q_a=32'h1234_5678; change data[2] to 32'h0000_0042 -> q_a follows one cycle later.
- Linger: req[1] pulsed 3 cycles, data[1]=32'h0000_00A5 -> gnt[1] 3 cycles, then gnt=0, busy=1, q_a stays 32'h0000_00A5. IDLE and q_a=idle_data exactly 8 cycles after grant edge.
- Round-robin preemption: req=4'b1011 held -> owners 0,1,3,0 in sequence, each exactly 8 cycles. gnt one-hot and never 0 across handoffs.
- Mid-hold reset: owner 2 at cycle 3 of hold, assert rst_n=0 -> gnt=0, q_a=0 at that edge. After release with req=4'b0100, owner 0? No: winner=2, because rr is reset to NREQ-1.
- SEG_LZB_EN build: grant data=32'h0000_1A00 -> digit_en=8'h0F; data=0 -> 8'h01. Non-LZB build -> 8'hFF.
